// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit and its datapath:
// opcodes, FSM states, ALU operation codes, select values and the control word.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_SLT   = 3'd5
    } aluop_t;

    localparam logic [SEL_W-1:0] REGDST_RT    = 2'd0;
    localparam logic [SEL_W-1:0] REGDST_RD    = 2'd1;
    localparam logic [SEL_W-1:0] REGDST_R31   = 2'd2;
    localparam logic [SEL_W-1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [SEL_W-1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [SEL_W-1:0] MEMTOREG_PC4 = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_REG     = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_SEXT    = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_SEXT_SH = 2'd3;
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic              pc_write;
        logic              pc_write_cond;
        logic              iord;
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              reg_write;
        logic              alu_src_a;
        logic [SEL_W-1:0]  reg_dst;
        logic [SEL_W-1:0]  mem_to_reg;
        logic [SEL_W-1:0]  alu_src_b;
        logic [SEL_W-1:0]  pc_source;
        aluop_t            alu_op;
        logic              trap;
    } ctrl_t;

    // ALU operation for the immediate-format arithmetic/logic instructions.
    function automatic aluop_t imm_aluop(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/next_state_logic.sv
// Combinational next-state dispatch for the multicycle control FSM.
module next_state_logic
    import multicycle_control_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  state_t                state_q,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ready,
    output state_t                next_state_c
);

    always_comb begin
        next_state_c = S_FETCH;
        case (state_q)
            S_FETCH:  next_state_c = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                         next_state_c = S_REXEC;
                    OP_LW, OP_SW:                     next_state_c = S_MEMADR;
                    OP_BEQ, OP_BNE:                   next_state_c = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state_c = S_IEXEC;
                    OP_J:                             next_state_c = S_JUMP;
                    OP_JAL:                           next_state_c = S_JAL;
                    default: next_state_c = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: next_state_c = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state_c = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state_c = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  next_state_c = S_RWB;
            S_IEXEC:  next_state_c = S_IWB;
            S_TRAP:   next_state_c = S_TRAP;
            // Write-back, branch, jump states and unused encodings all return to fetch.
            default:  next_state_c = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath; outputs decode from
// the state register and are forced to zero while reset is held low.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [SEL_W-1:0]     RegDst,
    output logic [SEL_W-1:0]     MemtoReg,
    output logic [SEL_W-1:0]     ALUSrcB,
    output logic [SEL_W-1:0]     PCSource,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic [STATE_W-1:0]   state,
    output logic                 trap
);

    state_t state_q;
    state_t next_state_c;
    ctrl_t  ctrl_c;

    next_state_logic #(
        .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
    ) u_next_state_logic (
        .state_q      (state_q),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .next_state_c (next_state_c)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= next_state_c;
        end
    end

    // Output decode; gating with reset kills every enable asynchronously.
    always_comb begin
        ctrl_c = '0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    ctrl_c.mem_read  = 1'b1;
                    ctrl_c.alu_src_b = SRCB_FOUR;
                    ctrl_c.pc_source = PCSRC_ALU;
                    ctrl_c.ir_write  = mem_ready;
                    ctrl_c.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl_c.alu_src_b = SRCB_SEXT_SH;
                end
                S_MEMADR: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = SRCB_SEXT;
                end
                S_MEMRD: begin
                    ctrl_c.iord     = 1'b1;
                    ctrl_c.mem_read = 1'b1;
                end
                S_MEMWR: begin
                    ctrl_c.iord      = 1'b1;
                    ctrl_c.mem_write = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = REGDST_RT;
                    ctrl_c.mem_to_reg = MEMTOREG_MEM;
                end
                S_REXEC: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = SRCB_REG;
                    ctrl_c.alu_op    = ALU_FUNCT;
                end
                S_RWB: begin
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = REGDST_RD;
                    ctrl_c.mem_to_reg = MEMTOREG_ALU;
                end
                S_BRANCH: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = SRCB_REG;
                    ctrl_c.alu_op    = ALU_SUB;
                    ctrl_c.pc_source = PCSRC_ALUOUT;
                    ctrl_c.pc_write  = ((opcode == OP_BEQ) && zero) ||
                                       ((opcode == OP_BNE) && !zero);
                end
                S_IEXEC: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = SRCB_SEXT;
                    ctrl_c.alu_op    = imm_aluop(opcode);
                end
                S_IWB: begin
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = REGDST_RT;
                    ctrl_c.mem_to_reg = MEMTOREG_ALU;
                end
                S_JUMP: begin
                    ctrl_c.pc_write  = 1'b1;
                    ctrl_c.pc_source = PCSRC_JUMP;
                end
                S_JAL: begin
                    ctrl_c.pc_write   = 1'b1;
                    ctrl_c.pc_source  = PCSRC_JUMP;
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = REGDST_R31;
                    ctrl_c.mem_to_reg = MEMTOREG_PC4;
                end
                S_TRAP: begin
                    ctrl_c.trap = 1'b1;
                end
                default: ctrl_c = '0;
            endcase
        end
    end

    assign PCWrite     = ctrl_c.pc_write;
    assign PCWriteCond = ctrl_c.pc_write_cond;
    assign IorD        = ctrl_c.iord;
    assign MemRead     = ctrl_c.mem_read;
    assign MemWrite    = ctrl_c.mem_write;
    assign IRWrite     = ctrl_c.ir_write;
    assign RegWrite    = ctrl_c.reg_write;
    assign ALUSrcA     = ctrl_c.alu_src_a;
    assign RegDst      = ctrl_c.reg_dst;
    assign MemtoReg    = ctrl_c.mem_to_reg;
    assign ALUSrcB     = ctrl_c.alu_src_b;
    assign PCSource    = ctrl_c.pc_source;
    assign ALUop       = ctrl_c.alu_op;
    assign trap        = ctrl_c.trap;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle
// expected states and control outputs, then drains the queue against the DUT.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       trap, pcw, pcwc, iord, mrd, mwr, irw, rw, srca;
        logic [1:0] rdst, m2r, srcb, pcsrc;
        logic [2:0] aluop;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic       z;
        vec_t       exp;
    } step_t;

    logic       CLK = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, trap;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    logic       nt_pcw, nt_pcwc, nt_iord, nt_mrd, nt_mwr, nt_irw, nt_rw, nt_srca, nt_trap;
    logic [1:0] nt_rdst, nt_m2r, nt_srcb, nt_pcsrc;
    logic [2:0] nt_aluop;
    logic [3:0] nt_state;

    vec_t  obs;
    step_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 CLK = ~CLK;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUop(ALUop), .state(state), .trap(trap)
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(nt_pcw), .PCWriteCond(nt_pcwc), .IorD(nt_iord), .MemRead(nt_mrd),
        .MemWrite(nt_mwr), .IRWrite(nt_irw), .RegWrite(nt_rw), .ALUSrcA(nt_srca),
        .RegDst(nt_rdst), .MemtoReg(nt_m2r), .ALUSrcB(nt_srcb), .PCSource(nt_pcsrc),
        .ALUop(nt_aluop), .state(nt_state), .trap(nt_trap)
    );

    assign obs = {state, trap, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  RegWrite, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSource, ALUop};

    // Expected control word for a state, written from the instruction-set tables.
    function automatic vec_t ref_vec(input logic [3:0] st, input logic [5:0] op,
                                     input logic z, input logic mr);
        vec_t v;
        v    = '0;
        v.st = st;
        case (st)
            4'd0:  begin v.mrd = 1'b1; v.srcb = 2'd1; v.irw = mr; v.pcw = mr; end
            4'd1:  v.srcb = 2'd3;
            4'd2:  begin v.srca = 1'b1; v.srcb = 2'd2; end
            4'd3:  begin v.iord = 1'b1; v.mrd = 1'b1; end
            4'd4:  begin v.rw = 1'b1; v.m2r = 2'd1; end
            4'd5:  begin v.iord = 1'b1; v.mwr = 1'b1; end
            4'd6:  begin v.srca = 1'b1; v.aluop = 3'd2; end
            4'd7:  begin v.rw = 1'b1; v.rdst = 2'd1; end
            4'd8:  begin
                v.srca = 1'b1; v.aluop = 3'd1; v.pcsrc = 2'd1;
                v.pcw  = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
            end
            4'd9:  begin
                v.srca = 1'b1; v.srcb = 2'd2;
                case (op)
                    6'b001100: v.aluop = 3'd3;
                    6'b001101: v.aluop = 3'd4;
                    6'b001010: v.aluop = 3'd5;
                    default:   v.aluop = 3'd0;
                endcase
            end
            4'd10: v.rw = 1'b1;
            4'd11: begin v.pcw = 1'b1; v.pcsrc = 2'd2; end
            4'd12: begin v.pcw = 1'b1; v.pcsrc = 2'd2; v.rw = 1'b1; v.rdst = 2'd2; v.m2r = 2'd2; end
            4'd15: v.trap = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic z);
        step_t s;
        s.st  = st;
        s.mr  = mr;
        s.z   = z;
        s.exp = ref_vec(st, opcode, z, mr);
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = 6'b100011; mem_ready = 1'b1; zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            n_checks++;
            if (obs !== vec_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: observed %h required %h", i, obs, vec_t'(0));
            end
        end
        @(posedge CLK); #2;
        reset = 1'b1;
    endtask

    task automatic test_lw();
        opcode = 6'b100011;
        push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b1, 1'b0);
        push(4'd3, 1'b1, 1'b0); push(4'd4, 1'b1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_t s = exp_q.pop_front();
            @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL lw step %0d: observed %h required %h", i, obs, s.exp);
            end
        end
    endtask

    task automatic test_sw_wait();
        opcode = 6'b101011;
        push(4'd0, 1'b0, 1'b0); push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0);
        push(4'd2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push(4'd5, 1'b0, 1'b0);
        push(4'd5, 1'b1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_t s = exp_q.pop_front();
            @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL sw_wait step %0d: observed %h required %h", i, obs, s.exp);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4];
        logic       zs  [4];
        ops[0] = 6'b000100; zs[0] = 1'b1;
        ops[1] = 6'b000100; zs[1] = 1'b0;
        ops[2] = 6'b000101; zs[2] = 1'b0;
        ops[3] = 6'b000101; zs[3] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            opcode = ops[c];
            push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd8, 1'b1, zs[c]);
            for (int i = 0; exp_q.size() > 0; i++) begin
                step_t s = exp_q.pop_front();
                @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL branch case %0d step %0d: observed %h required %h", c, i, obs, s.exp);
                end
            end
        end
    endtask

    task automatic test_alu_jump();
        logic [5:0] ops  [7];
        logic [3:0] st2  [7];
        logic [3:0] st3  [7];
        ops[0] = 6'b000000; st2[0] = 4'd6;  st3[0] = 4'd7;
        ops[1] = 6'b001000; st2[1] = 4'd9;  st3[1] = 4'd10;
        ops[2] = 6'b001100; st2[2] = 4'd9;  st3[2] = 4'd10;
        ops[3] = 6'b001101; st2[3] = 4'd9;  st3[3] = 4'd10;
        ops[4] = 6'b001010; st2[4] = 4'd9;  st3[4] = 4'd10;
        ops[5] = 6'b000010; st2[5] = 4'd11; st3[5] = 4'd0;
        ops[6] = 6'b000011; st2[6] = 4'd12; st3[6] = 4'd0;
        for (int c = 0; c < 7; c++) begin
            opcode = ops[c];
            push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0); push(st2[c], 1'b1, 1'b0);
            // Three-cycle jumps show their return to fetch with a held fetch cycle.
            push(st3[c], (c < 5) ? 1'b1 : 1'b0, 1'b0);
            for (int i = 0; exp_q.size() > 0; i++) begin
                step_t s = exp_q.pop_front();
                @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL alu_jump op %b step %0d: observed %h required %h", ops[c], i, obs, s.exp);
                end
            end
        end
    endtask

    task automatic test_trap();
        opcode = 6'b111111;
        push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++)
            push(4'd15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_t s = exp_q.pop_front();
            @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL trap step %0d: observed %h required %h", i, obs, s.exp);
            end
            if (i == 2) begin
                n_checks++;
                if (nt_state !== 4'd0) begin
                    n_fail++;
                    $display("FAIL illegal_nop state: observed %0d required 0", nt_state);
                end
            end
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL trap_async_reset: observed %h required %h", obs, vec_t'(0));
        end
        @(posedge CLK); #2;
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        opcode = 6'b100011;
        push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b1, 1'b0);
        push(4'd3, 1'b0, 1'b0); push(4'd3, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_t s = exp_q.pop_front();
            @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL mid_wait step %0d: observed %h required %h", i, obs, s.exp);
            end
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (MemRead !== 1'b0 || obs !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL mid_wait_abort: observed %h required %h", obs, vec_t'(0));
        end
        @(posedge CLK); #2;
        reset  = 1'b1;
        opcode = 6'b000010;
        push(4'd0, 1'b0, 1'b0); push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0);
        push(4'd11, 1'b1, 1'b0); push(4'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_t s = exp_q.pop_front();
            @(negedge CLK); mem_ready = s.mr; zero = s.z; #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL post_reset_fetch step %0d: observed %h required %h", i, obs, s.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_alu_jump();
        test_trap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TRAP_ON_ILLEGAL, default 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode is a NOP returning to FETCH.
REQ-002 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction-register bits [31:26], valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  output  1 each  datapath enables and selects.
REQ-008 SHALL have outputs RegDst, MemtoReg, ALUSrcB, PCSource  output  2 each  selects: RegDst 0=rt, 1=rd, 2=r31; MemtoReg 0=ALU, 1=mem, 2=PC+4; ALUSrcB 0=reg, 1=const 4, 2=sign-ext, 3=sign-ext<<2; PCSource 0=ALU, 1=ALUOut, 2=jump target.
REQ-009 SHALL have output ALUop  output  3  0=add, 1=sub, 2=funct, 3=and, 4=or, 5=slt.
REQ-010 SHALL have outputs state  output  4  current FSM state, and trap  output  1  high while in TRAP.

Function
REQ-011 SHALL implement a Moore FSM; all outputs decode from the registered state only. Exception: PCWrite in BRANCH depends on zero and opcode (REQ-016).
REQ-012 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JAL=12, TRAP=15.
REQ-013 FETCH behaviour:
- outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUop=add, PCSource=0.
- IRWrite=1 and PCWrite=1 only in the cycle with mem_ready=1, then go to DECODE.
- while mem_ready=0: hold FETCH with IRWrite=0, PCWrite=0.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ALUop=add (branch target), then dispatch on opcode:
- 000000 -> REXEC
- 100011, 101011 -> MEMADR
- 000100, 000101 -> BRANCH
- 001000, 001100, 001101, 001010 -> IEXEC
- 000010 -> JUMP
- 000011 -> JAL
- else -> TRAP or FETCH per TRAP_ON_ILLEGAL.
REQ-015 Memory path:
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUop=add; next MEMRD (lw) or MEMWR (sw).
- MEMRD/MEMWR: IorD=1 and MemRead/MemWrite asserted, held until mem_ready=1.
- MEMRD -> MEMWB on mem_ready; MEMWR -> FETCH on mem_ready.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUop=sub, PCSource=1; PCWrite=1 iff (opcode 000100 and zero) or (opcode 000101 and !zero); next FETCH.
REQ-017 R-type: REXEC drives ALUSrcA=1, ALUSrcB=0, ALUop=funct; RWB drives RegWrite=1, RegDst=1, MemtoReg=0.
REQ-018 Immediate: IEXEC drives ALUSrcA=1, ALUSrcB=2, ALUop = add/and/or/slt for addi/andi/ori/slti; IWB drives RegWrite=1, RegDst=0, MemtoReg=0.
REQ-019 JUMP SHALL drive PCWrite=1, PCSource=2. JAL SHALL additionally drive RegWrite=1, RegDst=2, MemtoReg=2. Both go to FETCH next.
REQ-020 TRAP SHALL be absorbing until reset, with every enable (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) low.
REQ-021 Any output not listed for a state SHALL be 0.
REQ-022 Unused state encodings SHALL go to FETCH on the next cycle with all enables low.
REQ-023 Latency: instructions SHALL take 3 cycles (branch, jump, jal), 4 cycles (R-type, immediate, sw) or 5 cycles (lw), each memory access adding one cycle per mem_ready=0 wait cycle.

Reset
REQ-024 While reset=0 the FSM SHALL be in FETCH asynchronously, with every enable output 0 and every select 0.
REQ-025 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction with no further write enable.
REQ-026 After reset release, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-027 Opcode constants, state encodings and ALUop codes SHALL live in a shared package used by the control block and the datapath.
REQ-028 One sub-module, next_state_logic (combinational dispatch from state, opcode and mem_ready), SHALL be instantiated; output decode stays in the top module.

Verification
REQ-029 Release reset, present lw (100011), mem_ready=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB.
REQ-030 sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held for 4 cycles, then FETCH; RegWrite never 1.
REQ-031 beq with zero=1 -> PCWrite=1 in BRANCH; repeat with zero=0 -> PCWrite=0; bne with zero=0 -> PCWrite=1.
REQ-032 jal -> 3 cycles; in JAL: PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-033 opcode 111111 with TRAP_ON_ILLEGAL=1 -> state 15, trap=1 held for 20 cycles; reset=0 -> state 0 immediately, without a clock edge.
REQ-034 Assert reset=0 in MEMRD during a wait -> MemRead drops asynchronously; after release, an instruction fetch completes normally.
